jtpang_objdma: RTL and testbench

- Object-table DMA engine that sits directly downstream of the main CPU block.
- It consumes the CPU's DMA trigger strobe, requests the Z80 bus through busrq_n/busak_n, and copies the object attribute table from shared main-side RAM into the object line-buffer RAM read by the object renderer.
- All traffic is paced by a clock enable, so the copy runs at CPU bus speed while the rest of the design runs on the 48 MHz system clock.

---
 rtl/jtpang_objdma_pkg.sv | 30 +++
 rtl/jtpang_objdma_edge.sv | 39 +++
 rtl/jtpang_objdma.sv | 212 +++++++++++++++++++++
 tb/tb_jtpang_objdma.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtpang_objdma_pkg.sv
// ---------------------------------------------------------------------------
// jtpang_objdma_pkg
//
// Shared definitions for the object-table DMA path.
//
// Contents:
//   ST_IDLE/ST_REQ/ST_XFER/ST_DONE : DMA controller state encoding
//   DEF_SRC_AW / DEF_DST_AW        : default source / destination address widths
//   DEF_LEN                        : default object table size in bytes
//   DEF_SRC_BASE                   : default first source address of the table
//
// The object renderer reads DEF_LEN to know how many attribute bytes the line
// buffer holds, so the DMA engine and the renderer agree on the table size.
// ---------------------------------------------------------------------------
package jtpang_objdma_pkg;

  // DMA controller state encoding, kept as plain constants so older tools
  // that cannot handle enums in state registers still accept the design.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Default geometry of the object attribute table.
  localparam int         DEF_SRC_AW   = 12;
  localparam int         DEF_DST_AW   = 9;
  localparam int         DEF_LEN      = 512;
  localparam logic [11:0] DEF_SRC_BASE = 12'h000;

endpackage

// File: rtl/jtpang_objdma_edge.sv
// ---------------------------------------------------------------------------
// jtpang_objdma_edge
//
// Rising-edge detector with synchronous active-high reset. The input is
// compared against a registered copy of itself, so a level that stays high
// for many clocks produces exactly one single-clock pulse. Also intended for
// the vblank and IRQ edges elsewhere in the design.
//
// Ports:
//   clk    in  system clock
//   rst    in  synchronous reset, active-high; clears the registered copy
//   sig_i  in  level to watch
//   rise_o out high for the clock in which sig_i is high and was low on the
//              previous clock edge
// ---------------------------------------------------------------------------
module jtpang_objdma_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sigDly_q;

  // Keep last clock's copy of the input. Clearing it on reset means a level
  // that is already high when reset drops still counts as a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sigDly_q <= 1'b0;
    end else begin
      sigDly_q <= sig_i;
    end
  end

  // The pulse is combinational so the consumer can act on the same edge in
  // which the level is first seen high.
  assign rise_o = sig_i & ~sigDly_q;

endmodule

// File: rtl/jtpang_objdma.sv
// ---------------------------------------------------------------------------
// jtpang_objdma
//
// Object-table DMA engine. On a rising edge of the CPU trigger it requests
// the Z80 bus, then copies LEN bytes from main-side object RAM (starting at
// SRC_BASE) into the object line-buffer RAM (starting at address 0), one byte
// per cen pulse, and finally releases the bus.
//
// Parameters:
//   SRC_AW   source address width
//   DST_AW   destination address width
//   SRC_BASE first source address copied (source addresses wrap)
//   LEN      bytes per transfer, 1 .. 2**DST_AW
//
// Ports:
//   clk      in  system clock
//   rst      in  synchronous reset, active-high
//   cen      in  pacing enable, one byte moved per pulse
//   dma_go   in  trigger level from CPU I/O decode
//   busrq_n  out Z80 bus request, active low
//   busak_n  in  Z80 bus acknowledge, active low
//   src_addr out source RAM address
//   src_rd   out source read strobe
//   src_dout in  source data, valid on the cen after the address is issued
//   dst_addr out object buffer address
//   dst_din  out object buffer write data
//   dst_we   out object buffer write enable, one clk wide
//   busy     out high from trigger acceptance until bus release
// ---------------------------------------------------------------------------
module jtpang_objdma
  import jtpang_objdma_pkg::*;
#(
  parameter int                SRC_AW   = DEF_SRC_AW,
  parameter int                DST_AW   = DEF_DST_AW,
  parameter logic [SRC_AW-1:0] SRC_BASE = SRC_AW'(DEF_SRC_BASE),
  parameter int                LEN      = DEF_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              dma_go,
  output logic              busrq_n,
  input  logic              busak_n,
  output logic [SRC_AW-1:0] src_addr,
  output logic              src_rd,
  input  logic [7:0]        src_dout,
  output logic [DST_AW-1:0] dst_addr,
  output logic [7:0]        dst_din,
  output logic              dst_we,
  output logic              busy
);

  // One extra counter bit so a full 2**DST_AW table has a representable
  // terminal count.
  localparam int               CNT_W   = DST_AW + 1;
  localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]        state_q,   state_d;
  logic [CNT_W-1:0]  rdCnt_q,   rdCnt_d;
  logic [CNT_W-1:0]  wrCnt_q,   wrCnt_d;
  logic              busrqN_q,  busrqN_d;
  logic              busy_q,    busy_d;
  logic [SRC_AW-1:0] srcAddr_q, srcAddr_d;
  logic              srcRd_q,   srcRd_d;
  logic [DST_AW-1:0] dstAddr_q, dstAddr_d;
  logic [7:0]        dstDin_q,  dstDin_d;
  logic              dstWe_q,   dstWe_d;
  logic              reissue_q, reissue_d;

  logic goRise;
  logic inFlight;

  // Trigger edge detection lives in the reusable sub-module; the held level
  // from the CPU decode therefore only ever starts one transfer.
  jtpang_objdma_edge u_goEdge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (dma_go),
    .rise_o (goRise)
  );

  // A byte is in flight whenever an address has been issued whose data has
  // not been written yet, i.e. stage A is ahead of stage B.
  assign inFlight = (rdCnt_q != wrCnt_q);

  // Next-state logic for the controller and the two-stage copy pipeline.
  // Stage A issues a source address; stage B, on the following cen, writes
  // the returned data. Both stages act on the same cen, so in steady state a
  // byte is read and the previous one written on every pulse.
  // If the CPU takes the bus back mid-copy everything freezes. Because the
  // source RAM may have been driven by the CPU meanwhile, the first cen after
  // the bus returns re-issues the outstanding address instead of writing
  // stale data, and the normal overlap resumes on the cen after that.
  // A trigger edge while not idle falls through every other case, so it is
  // dropped rather than queued.
  always_comb begin
    state_d   = state_q;
    rdCnt_d   = rdCnt_q;
    wrCnt_d   = wrCnt_q;
    busrqN_d  = busrqN_q;
    busy_d    = busy_q;
    srcAddr_d = srcAddr_q;
    srcRd_d   = srcRd_q;
    dstAddr_d = dstAddr_q;
    dstDin_d  = dstDin_q;
    dstWe_d   = 1'b0;
    reissue_d = reissue_q;

    case (state_q)
      ST_IDLE: begin
        if (goRise) begin
          busy_d    = 1'b1;
          busrqN_d  = 1'b0;
          rdCnt_d   = '0;
          wrCnt_d   = '0;
          reissue_d = 1'b0;
          state_d   = ST_REQ;
        end
      end

      ST_REQ: begin
        if (!busak_n) begin
          state_d = ST_XFER;
        end
      end

      ST_XFER: begin
        if (busak_n) begin
          if (inFlight) begin
            reissue_d = 1'b1;
          end
        end else if (cen) begin
          if (reissue_q && inFlight) begin
            srcAddr_d = SRC_BASE + SRC_AW'(rdCnt_q - CNT_ONE);
            srcRd_d   = 1'b1;
            reissue_d = 1'b0;
          end else begin
            reissue_d = 1'b0;
            if (rdCnt_q != LEN_C) begin
              srcAddr_d = SRC_BASE + SRC_AW'(rdCnt_q);
              srcRd_d   = 1'b1;
              rdCnt_d   = rdCnt_q + CNT_ONE;
            end else begin
              srcRd_d   = 1'b0;
            end
            if (inFlight) begin
              dstDin_d  = src_dout;
              dstAddr_d = wrCnt_q[DST_AW-1:0];
              dstWe_d   = 1'b1;
              wrCnt_d   = wrCnt_q + CNT_ONE;
              if ((wrCnt_q + CNT_ONE) == LEN_C) begin
                state_d = ST_DONE;
              end
            end
          end
        end
      end

      ST_DONE: begin
        busrqN_d = 1'b1;
        busy_d   = 1'b0;
        srcRd_d  = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state registers. Reset is synchronous: one clock with rst high puts
  // every output back to its idle value and lets go of the Z80 bus at once.
  // Whatever was already written to the object buffer stays there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rdCnt_q   <= '0;
      wrCnt_q   <= '0;
      busrqN_q  <= 1'b1;
      busy_q    <= 1'b0;
      srcAddr_q <= SRC_BASE;
      srcRd_q   <= 1'b0;
      dstAddr_q <= '0;
      dstDin_q  <= '0;
      dstWe_q   <= 1'b0;
      reissue_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdCnt_q   <= rdCnt_d;
      wrCnt_q   <= wrCnt_d;
      busrqN_q  <= busrqN_d;
      busy_q    <= busy_d;
      srcAddr_q <= srcAddr_d;
      srcRd_q   <= srcRd_d;
      dstAddr_q <= dstAddr_d;
      dstDin_q  <= dstDin_d;
      dstWe_q   <= dstWe_d;
      reissue_q <= reissue_d;
    end
  end

  assign busrq_n  = busrqN_q;
  assign busy     = busy_q;
  assign src_addr = srcAddr_q;
  assign src_rd   = srcRd_q;
  assign dst_addr = dstAddr_q;
  assign dst_din  = dstDin_q;
  assign dst_we   = dstWe_q;

endmodule

// File: tb/tb_jtpang_objdma.sv
// ---------------------------------------------------------------------------
// tb_jtpang_objdma
//
// Testbench for the object-table DMA engine. Three instances share clock,
// reset and cen: the full-size table (LEN=512, base 0x000) and two tiny
// tables starting at 0xFFF (LEN=1 and LEN=2) for the wrap-around boundary.
// Source RAM holds addr[7:0]^8'h5A everywhere.
// ---------------------------------------------------------------------------
module tb_jtpang_objdma;
  import jtpang_objdma_pkg::*;

  localparam int BIG_LEN = DEF_LEN;

  typedef struct {
    string name;
    int    holdClks;
    int    secondEdgeAt;
    int    lossAt;
    int    lossClks;
    int    expWrites;
    int    expStarts;
    int    expBad;
    int    expFirstAddr;
  } scen_t;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } spot_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b0;

  logic        goA = 1'b0, busrqA_n, busakA_n = 1'b1, srcRdA, weA, busyA;
  logic [11:0] srcA_addr;
  logic [7:0]  srcA_dout, dstA_din;
  logic [8:0]  dstA_addr;

  logic        goB = 1'b0, busrqB_n, busakB_n, srcRdB, weB, busyB;
  logic [11:0] srcB_addr;
  logic [7:0]  srcB_dout, dstB_din;
  logic [8:0]  dstB_addr;

  logic        goC = 1'b0, busrqC_n, busakC_n, srcRdC, weC, busyC;
  logic [11:0] srcC_addr;
  logic [7:0]  srcC_dout, dstC_din;
  logic [8:0]  dstC_addr;

  logic [7:0] srcMem [4096];
  logic [7:0] dstMem [512];
  int         dstHits [512];

  int checkCount = 0;
  int passCount  = 0;
  int cycle      = 0;
  int writeCount, firstWriteAddr, weWhileLost, starts;
  int lastWriteCycle, releaseCycle, ackCnt;
  logic busrqAtLastWrite, prevBusyA;
  bit cenManual = 1'b0;
  bit lossForce = 1'b0;

  always #5 clk = ~clk;

  assign srcA_dout = srcMem[srcA_addr];
  assign srcB_dout = srcMem[srcB_addr];
  assign srcC_dout = srcMem[srcC_addr];
  assign busakB_n  = busrqB_n;
  assign busakC_n  = busrqC_n;

  jtpang_objdma #(.SRC_AW(12), .DST_AW(9), .SRC_BASE(12'h000), .LEN(BIG_LEN)) dutA (
    .clk(clk), .rst(rst), .cen(cen), .dma_go(goA), .busrq_n(busrqA_n), .busak_n(busakA_n),
    .src_addr(srcA_addr), .src_rd(srcRdA), .src_dout(srcA_dout), .dst_addr(dstA_addr),
    .dst_din(dstA_din), .dst_we(weA), .busy(busyA)
  );

  jtpang_objdma #(.SRC_AW(12), .DST_AW(9), .SRC_BASE(12'hFFF), .LEN(1)) dutB (
    .clk(clk), .rst(rst), .cen(cen), .dma_go(goB), .busrq_n(busrqB_n), .busak_n(busakB_n),
    .src_addr(srcB_addr), .src_rd(srcRdB), .src_dout(srcB_dout), .dst_addr(dstB_addr),
    .dst_din(dstB_din), .dst_we(weB), .busy(busyB)
  );

  jtpang_objdma #(.SRC_AW(12), .DST_AW(9), .SRC_BASE(12'hFFF), .LEN(2)) dutC (
    .clk(clk), .rst(rst), .cen(cen), .dma_go(goC), .busrq_n(busrqC_n), .busak_n(busakC_n),
    .src_addr(srcC_addr), .src_rd(srcRdC), .src_dout(srcC_dout), .dst_addr(dstC_addr),
    .dst_din(dstC_din), .dst_we(weC), .busy(busyC)
  );

  // Compare one observed value with its expected value and keep score.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  // Advance one clock, sample instance A one delta after the edge, then
  // update the Z80 acknowledge model and the free-running cen.
  task automatic stepClk();
    @(posedge clk);
    #1;
    cycle++;
    if (weA) begin
      writeCount++;
      if (firstWriteAddr < 0) firstWriteAddr = int'(dstA_addr);
      dstMem[dstA_addr] = dstA_din;
      dstHits[dstA_addr]++;
      if (busakA_n) weWhileLost++;
      lastWriteCycle   = cycle;
      busrqAtLastWrite = busrqA_n;
    end
    if (busyA && !prevBusyA) starts++;
    if (!busyA && prevBusyA) releaseCycle = cycle;
    prevBusyA = busyA;
    if (busrqA_n) begin
      ackCnt   = 0;
      busakA_n = 1'b1;
    end else begin
      if (ackCnt < 3) ackCnt++;
      busakA_n = (ackCnt >= 3 && !lossForce) ? 1'b0 : 1'b1;
    end
    if (!cenManual) cen = ((cycle % 8) == 0);
  endtask

  task automatic clearTracking();
    writeCount       = 0;
    firstWriteAddr   = -1;
    weWhileLost      = 0;
    starts           = 0;
    lastWriteCycle   = 0;
    releaseCycle     = 0;
    busrqAtLastWrite = 1'b1;
    for (int i = 0; i < 512; i++) begin
      dstHits[i] = 0;
      dstMem[i]  = 8'h00;
    end
  endtask

  // Addresses not written exactly once, or holding the wrong byte.
  function automatic int countBad();
    int bad = 0;
    for (int i = 0; i < BIG_LEN; i++) begin
      if (dstHits[i] != 1 || dstMem[i] !== (8'(i) ^ 8'h5A)) bad++;
    end
    return bad;
  endfunction

  task automatic runUntilIdle(input int budget, output bit timedOut);
    timedOut = 1'b1;
    for (int n = 0; n < budget; n++) begin
      stepClk();
      if (starts > 0 && !busyA) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  // Run one full-size transfer scenario from the table on instance A.
  task automatic applyStimulus(input scen_t v, output bit timedOut);
    int  holdLeft;
    int  lossLeft;
    bit  secondDone;
    bit  lossDone;
    clearTracking();
    goA        = 1'b1;
    holdLeft   = v.holdClks;
    lossLeft   = 0;
    secondDone = 1'b0;
    lossDone   = 1'b0;
    timedOut   = 1'b1;
    for (int n = 0; n < 8000; n++) begin
      stepClk();
      if (holdLeft > 0) begin
        holdLeft--;
        if (holdLeft == 0) goA = 1'b0;
      end
      if (v.secondEdgeAt >= 0 && !secondDone && writeCount >= v.secondEdgeAt) begin
        goA        = 1'b1;
        holdLeft   = 2;
        secondDone = 1'b1;
      end
      if (lossLeft > 0) begin
        lossLeft--;
        if (lossLeft == 0) lossForce = 1'b0;
      end
      if (v.lossAt >= 0 && !lossDone && writeCount >= v.lossAt) begin
        lossForce = 1'b1;
        busakA_n  = 1'b1;
        lossLeft  = v.lossClks;
        lossDone  = 1'b1;
      end
      if (starts > 0 && !busyA) begin
        timedOut = 1'b0;
        break;
      end
    end
    goA       = 1'b0;
    lossForce = 1'b0;
    repeat (150) stepClk();
  endtask

  // Overall time limit so the bench can never hang.
  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    scen_t scen [3];
    spot_t spots [6];
    bit    timedOut;

    scen[0] = '{"basic",   1, -1,  -1,  0, 512, 1, 0, 0};
    scen[1] = '{"heldGo", 20, 200, -1,  0, 512, 1, 0, 0};
    scen[2] = '{"busLoss", 2, -1, 100, 30, 512, 1, 0, 0};

    spots[0] = '{0,   8'h5A};
    spots[1] = '{1,   8'h5B};
    spots[2] = '{100, 8'h3E};
    spots[3] = '{255, 8'hA5};
    spots[4] = '{256, 8'h5A};
    spots[5] = '{511, 8'hA5};

    for (int i = 0; i < 4096; i++) srcMem[i] = 8'(i) ^ 8'h5A;
    prevBusyA = 1'b0;
    ackCnt    = 0;
    clearTracking();

    $display("[TB] reset");
    rst = 1'b1;
    repeat (3) stepClk();
    checkOutput("rst.busrq_n",  32'(busrqA_n), 32'd1);
    checkOutput("rst.busy",     32'(busyA),    32'd0);
    checkOutput("rst.src_rd",   32'(srcRdA),   32'd0);
    checkOutput("rst.dst_we",   32'(weA),      32'd0);
    checkOutput("rst.src_addr", 32'(srcA_addr), 32'h000);
    checkOutput("rst.dst_addr", 32'(dstA_addr), 32'd0);
    checkOutput("rst.dst_din",  32'(dstA_din),  32'd0);
    checkOutput("rst.srcBaseB", 32'(srcB_addr), 32'hFFF);
    rst = 1'b0;
    repeat (4) stepClk();

    for (int s = 0; s < 3; s++) begin
      $display("[TB] scenario %s", scen[s].name);
      applyStimulus(scen[s], timedOut);
      checkOutput({scen[s].name, ".timeout"},   32'(timedOut),         32'd0);
      checkOutput({scen[s].name, ".writes"},    32'(writeCount),       32'(scen[s].expWrites));
      checkOutput({scen[s].name, ".starts"},    32'(starts),           32'(scen[s].expStarts));
      checkOutput({scen[s].name, ".weLost"},    32'(weWhileLost),      32'd0);
      checkOutput({scen[s].name, ".badBytes"},  32'(countBad()),       32'(scen[s].expBad));
      checkOutput({scen[s].name, ".firstAddr"}, 32'(firstWriteAddr),   32'(scen[s].expFirstAddr));
      checkOutput({scen[s].name, ".busrqLast"}, 32'(busrqAtLastWrite), 32'd0);
      checkOutput({scen[s].name, ".release"},   32'(releaseCycle - lastWriteCycle), 32'd1);
      checkOutput({scen[s].name, ".busyEnd"},   32'(busyA),            32'd0);
      checkOutput({scen[s].name, ".busrqEnd"},  32'(busrqA_n),         32'd1);
      for (int k = 0; k < 6; k++) begin
        checkOutput($sformatf("%s.dst[%0d]", scen[s].name, spots[k].addr),
                    32'(dstMem[spots[k].addr]), 32'(spots[k].data));
      end
    end

    $display("[TB] reset mid-transfer");
    clearTracking();
    goA = 1'b1;
    stepClk();
    goA = 1'b0;
    timedOut = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      stepClk();
      if (writeCount >= 37) begin
        timedOut = 1'b0;
        break;
      end
    end
    checkOutput("midRst.reach37", 32'(timedOut), 32'd0);
    rst = 1'b1;
    stepClk();
    rst = 1'b0;
    checkOutput("midRst.busrq_n",  32'(busrqA_n),  32'd1);
    checkOutput("midRst.busy",     32'(busyA),     32'd0);
    checkOutput("midRst.dst_we",   32'(weA),       32'd0);
    checkOutput("midRst.src_rd",   32'(srcRdA),    32'd0);
    checkOutput("midRst.dst_addr", 32'(dstA_addr), 32'd0);
    checkOutput("midRst.writes",   32'(writeCount), 32'd37);
    repeat (5) stepClk();
    clearTracking();
    goA = 1'b1;
    stepClk();
    goA = 1'b0;
    runUntilIdle(8000, timedOut);
    checkOutput("restart.timeout",   32'(timedOut),       32'd0);
    checkOutput("restart.firstAddr", 32'(firstWriteAddr), 32'd0);
    checkOutput("restart.writes",    32'(writeCount),     32'd512);
    checkOutput("restart.badBytes",  32'(countBad()),     32'd0);
    repeat (10) stepClk();

    $display("[TB] trigger coincident with cen");
    clearTracking();
    cenManual = 1'b1;
    goA = 1'b1;
    cen = 1'b1;
    stepClk();
    checkOutput("coinc.busy",     32'(busyA),    32'd1);
    checkOutput("coinc.busrq_n",  32'(busrqA_n), 32'd0);
    checkOutput("coinc.src_rd",   32'(srcRdA),   32'd0);
    goA = 1'b0;
    cen = 1'b0;
    repeat (6) stepClk();
    checkOutput("coinc.ackLow",   32'(busakA_n), 32'd0);
    checkOutput("coinc.noRdYet",  32'(srcRdA),   32'd0);
    cen = 1'b1;
    stepClk();
    cen = 1'b0;
    checkOutput("coinc.firstRd",  32'(srcRdA),    32'd1);
    checkOutput("coinc.firstAdr", 32'(srcA_addr), 32'h000);
    checkOutput("coinc.noWe",     32'(weA),       32'd0);
    cenManual = 1'b0;
    runUntilIdle(8000, timedOut);
    checkOutput("coinc.timeout",  32'(timedOut),   32'd0);
    checkOutput("coinc.writes",   32'(writeCount), 32'd512);
    checkOutput("coinc.badBytes", 32'(countBad()), 32'd0);
    repeat (10) stepClk();

    $display("[TB] LEN=1 at 0xFFF");
    cenManual = 1'b1;
    cen = 1'b0;
    goB = 1'b1;
    stepClk();
    goB = 1'b0;
    stepClk();
    cen = 1'b1;
    stepClk();
    cen = 1'b0;
    checkOutput("len1.srcAddr", 32'(srcB_addr), 32'hFFF);
    checkOutput("len1.srcRd",   32'(srcRdB),    32'd1);
    checkOutput("len1.noWe",    32'(weB),       32'd0);
    repeat (2) stepClk();
    cen = 1'b1;
    stepClk();
    cen = 1'b0;
    checkOutput("len1.we",      32'(weB),       32'd1);
    checkOutput("len1.dstAddr", 32'(dstB_addr), 32'd0);
    checkOutput("len1.dstDin",  32'(dstB_din),  32'hA5);
    checkOutput("len1.rdDrop",  32'(srcRdB),    32'd0);
    stepClk();
    checkOutput("len1.weOnce",  32'(weB),       32'd0);
    checkOutput("len1.busy",    32'(busyB),     32'd0);
    checkOutput("len1.busrq_n", 32'(busrqB_n),  32'd1);

    $display("[TB] LEN=2 at 0xFFF");
    goC = 1'b1;
    stepClk();
    goC = 1'b0;
    stepClk();
    cen = 1'b1;
    stepClk();
    cen = 1'b0;
    checkOutput("len2.srcAddr0", 32'(srcC_addr), 32'hFFF);
    stepClk();
    cen = 1'b1;
    stepClk();
    cen = 1'b0;
    checkOutput("len2.srcWrap",  32'(srcC_addr), 32'h000);
    checkOutput("len2.we0",      32'(weC),       32'd1);
    checkOutput("len2.dst0",     32'(dstC_addr), 32'd0);
    checkOutput("len2.din0",     32'(dstC_din),  32'hA5);
    stepClk();
    checkOutput("len2.wePulse",  32'(weC),       32'd0);
    cen = 1'b1;
    stepClk();
    cen = 1'b0;
    checkOutput("len2.we1",      32'(weC),       32'd1);
    checkOutput("len2.dst1",     32'(dstC_addr), 32'd1);
    checkOutput("len2.din1",     32'(dstC_din),  32'h5A);
    checkOutput("len2.rdDrop",   32'(srcRdC),    32'd0);
    stepClk();
    checkOutput("len2.busy",     32'(busyC),     32'd0);
    checkOutput("len2.busrq_n",  32'(busrqC_n),  32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
